// File: rtl/memory_rst_pkg.sv
// Shared constants and types for the memory_rst register slice.
// Optional Qn output is selected with the MEMORY_RST_QN_EN macro.
package memory_rst_pkg;

    localparam int MEMORY_RST_MAX_WIDTH     = 64;
    localparam int MEMORY_RST_DEFAULT_WIDTH = 1;

    typedef logic [MEMORY_RST_MAX_WIDTH-1:0] memory_rst_word_t;

    localparam memory_rst_word_t MEMORY_RST_DEFAULT_RST_VAL = '0;

    function automatic logic memory_rst_width_ok(input int width);
        return (width >= 1) && (width <= MEMORY_RST_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/memory_rst_if.sv
// Data bundle for memory_rst: D in, Q out, and Qn when MEMORY_RST_QN_EN is defined.
interface memory_rst_if
    import memory_rst_pkg::*;
#(
    parameter int WIDTH = MEMORY_RST_DEFAULT_WIDTH
);

    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
`ifdef MEMORY_RST_QN_EN
    logic [WIDTH-1:0] Qn;
`endif

`ifdef MEMORY_RST_QN_EN
    modport master (output D, input Q, input Qn);
    modport slave  (input D, output Q, output Qn);
`else
    modport master (output D, input Q);
    modport slave  (input D, output Q);
`endif

endinterface

// File: rtl/memory_rst_bit.sv
// Single-bit flop with asynchronous active-high reset to a per-bit value.
module memory_rst_bit #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic q_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= RST_VAL;
        end else begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/memory_rst.sv
// WIDTH-bit register with asynchronous reset to RST_VAL.
// Define MEMORY_RST_QN_EN to add the complemented output Qn.
module memory_rst
    import memory_rst_pkg::*;
#(
    parameter int               WIDTH   = MEMORY_RST_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(MEMORY_RST_DEFAULT_RST_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
`ifdef MEMORY_RST_QN_EN
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
`else
    output logic [WIDTH-1:0] Q
`endif
);

    if (!memory_rst_width_ok(WIDTH)) begin : g_width_check
        $error("memory_rst: WIDTH=%0d outside legal range 1..%0d",
               WIDTH, MEMORY_RST_MAX_WIDTH);
    end

    // Each bit is an independent flop so bit i of Q only ever sees bit i of D.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        memory_rst_bit #(
            .RST_VAL (RST_VAL[gi])
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .d   (D[gi]),
            .q   (Q[gi])
        );
    end

`ifdef MEMORY_RST_QN_EN
    // Qn comes straight off the same storage, so it can never disagree with Q.
    assign Qn = ~Q;
`endif

endmodule

// File: tb/tb_memory_rst.sv
// Self-checking bench for memory_rst: a 1-bit default instance and an 8-bit RST_VAL=A5 instance.
module tb_memory_rst;

    localparam logic       RV1 = 1'b0;
    localparam logic [7:0] RV8 = 8'hA5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: value each register should hold right now.
    logic       exp1;
    logic [7:0] exp8;

    memory_rst_if #(.WIDTH(1)) bus1 ();
    memory_rst_if #(.WIDTH(8)) bus8 ();

    memory_rst u_dut1 (
        .clk (clk),
        .rst (rst),
        .D   (bus1.D),
`ifdef MEMORY_RST_QN_EN
        .Q   (bus1.Q),
        .Qn  (bus1.Qn)
`else
        .Q   (bus1.Q)
`endif
    );

    memory_rst #(
        .WIDTH   (8),
        .RST_VAL (RV8)
    ) u_dut8 (
        .clk (clk),
        .rst (rst),
        .D   (bus8.D),
`ifdef MEMORY_RST_QN_EN
        .Q   (bus8.Q),
        .Qn  (bus8.Qn)
`else
        .Q   (bus8.Q)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        bus1.D = 1'b1;
        bus8.D = 8'h3C;
        exp1 = RV1;
        exp8 = RV8;
        #1;
        checks++;
        if (bus1.Q !== exp1) begin errors++; $display("FAIL reset_q1: got %h expected %h", bus1.Q, exp1); end
        checks++;
        if (bus8.Q !== exp8) begin errors++; $display("FAIL reset_q8: got %h expected %h", bus8.Q, exp8); end
`ifdef MEMORY_RST_QN_EN
        checks++;
        if (bus8.Qn !== ~exp8) begin errors++; $display("FAIL reset_qn8: got %h expected %h", bus8.Qn, ~exp8); end
`endif
        $display("txn reset: Q1=%h Q8=%h", bus1.Q, bus8.Q);
    endtask

    task automatic test_edge_during_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus1.D = 1'b1;
            bus8.D = 8'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (bus1.Q !== RV1) begin errors++; $display("FAIL edge_in_reset_q1: got %h expected %h", bus1.Q, RV1); end
            checks++;
            if (bus8.Q !== RV8) begin errors++; $display("FAIL edge_in_reset_q8: got %h expected %h", bus8.Q, RV8); end
            $display("txn edge_in_reset: D8=%h Q8=%h", bus8.D, bus8.Q);
        end
    endtask

    task automatic test_reset_release();
        @(negedge clk);
        bus1.D = 1'b1;
        bus8.D = 8'h3C;
        rst = 1'b0;
        #4;
        checks++;
        if (bus1.Q !== RV1) begin errors++; $display("FAIL release_hold_q1: got %h expected %h", bus1.Q, RV1); end
        checks++;
        if (bus8.Q !== RV8) begin errors++; $display("FAIL release_hold_q8: got %h expected %h", bus8.Q, RV8); end
        @(posedge clk);
        #1;
        exp1 = 1'b1;
        exp8 = 8'h3C;
        checks++;
        if (bus1.Q !== exp1) begin errors++; $display("FAIL release_load_q1: got %h expected %h", bus1.Q, exp1); end
        checks++;
        if (bus8.Q !== exp8) begin errors++; $display("FAIL release_load_q8: got %h expected %h", bus8.Q, exp8); end
`ifdef MEMORY_RST_QN_EN
        checks++;
        if (bus8.Qn !== 8'hC3) begin errors++; $display("FAIL release_load_qn8: got %h expected %h", bus8.Qn, 8'hC3); end
`endif
        $display("txn release: Q1=%h Q8=%h", bus1.Q, bus8.Q);
    endtask

    task automatic test_capture();
        logic [1:0] pat = 2'b10;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus1.D = pat[i];
            bus8.D = 8'($urandom);
            exp1 = bus1.D;
            exp8 = bus8.D;
            @(posedge clk);
            #1;
            checks++;
            if (bus1.Q !== exp1) begin errors++; $display("FAIL capture_q1: got %h expected %h", bus1.Q, exp1); end
            checks++;
            if (bus8.Q !== exp8) begin errors++; $display("FAIL capture_q8: got %h expected %h", bus8.Q, exp8); end
            $display("txn capture: D1=%h Q1=%h D8=%h Q8=%h", bus1.D, bus1.Q, bus8.D, bus8.Q);
        end
    endtask

    task automatic test_data_glitch();
        logic [7:0] final8;
        // exp1 is 1 from test_capture; toggle D1 1->0->1 between edges.
        #1;
        bus1.D = 1'b0;
        bus8.D = ~exp8;
        #1;
        checks++;
        if (bus1.Q !== exp1) begin errors++; $display("FAIL glitch_mid_q1: got %h expected %h", bus1.Q, exp1); end
        checks++;
        if (bus8.Q !== exp8) begin errors++; $display("FAIL glitch_mid_q8: got %h expected %h", bus8.Q, exp8); end
        @(negedge clk);
        bus1.D = 1'b1;
        final8 = 8'($urandom);
        bus8.D = final8;
        #1;
        checks++;
        if (bus1.Q !== exp1) begin errors++; $display("FAIL glitch_neg_q1: got %h expected %h", bus1.Q, exp1); end
        checks++;
        if (bus8.Q !== exp8) begin errors++; $display("FAIL glitch_neg_q8: got %h expected %h", bus8.Q, exp8); end
        @(posedge clk);
        #1;
        exp1 = 1'b1;
        exp8 = final8;
        checks++;
        if (bus1.Q !== exp1) begin errors++; $display("FAIL glitch_edge_q1: got %h expected %h", bus1.Q, exp1); end
        checks++;
        if (bus8.Q !== exp8) begin errors++; $display("FAIL glitch_edge_q8: got %h expected %h", bus8.Q, exp8); end
        $display("txn glitch: Q1=%h Q8=%h", bus1.Q, bus8.Q);
    endtask

    task automatic test_async_reset();
        // Clock is high here (just after a rising edge) and stays high through the check.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        exp1 = RV1;
        exp8 = RV8;
        checks++;
        if (bus1.Q !== exp1) begin errors++; $display("FAIL async_q1: got %h expected %h", bus1.Q, exp1); end
        checks++;
        if (bus8.Q !== exp8) begin errors++; $display("FAIL async_q8: got %h expected %h", bus8.Q, exp8); end
`ifdef MEMORY_RST_QN_EN
        checks++;
        if (bus8.Qn !== 8'h5A) begin errors++; $display("FAIL async_qn8: got %h expected %h", bus8.Qn, 8'h5A); end
`endif
        $display("txn async_reset: clk=%b Q1=%h Q8=%h", clk, bus1.Q, bus8.Q);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 7) == 0);
            bus1.D = 1'($urandom);
            bus8.D = 8'($urandom);
            exp1 = rst ? RV1 : bus1.D;
            exp8 = rst ? RV8 : bus8.D;
            @(posedge clk);
            #1;
            checks++;
            if (bus1.Q !== exp1) begin errors++; $display("FAIL random_q1: got %h expected %h", bus1.Q, exp1); end
            checks++;
            if (bus8.Q !== exp8) begin errors++; $display("FAIL random_q8: got %h expected %h", bus8.Q, exp8); end
`ifdef MEMORY_RST_QN_EN
            checks++;
            if (bus8.Qn !== ~exp8) begin errors++; $display("FAIL random_qn8: got %h expected %h", bus8.Qn, ~exp8); end
`endif
            // Scramble D mid-cycle; the stored value must not move.
            bus1.D = ~bus1.D;
            bus8.D = 8'($urandom);
            #1;
            checks++;
            if (bus8.Q !== exp8) begin errors++; $display("FAIL random_hold_q8: got %h expected %h", bus8.Q, exp8); end
            $display("txn random %0d: rst=%b Q1=%h Q8=%h", i, rst, bus1.Q, bus8.Q);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_edge_during_reset();
        test_reset_release();
        test_capture();
        test_data_glitch();
        test_async_reset();
        test_capture();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_rst.md
MEMORY_RST -- requirements
Module: memory_rst

Interface
REQ-001 Parameter WIDTH, default 1, sets the data width in bits; legal range 1..64.
REQ-002 Parameter RST_VAL, default all-zeros (WIDTH bits), sets the value Q takes during reset.
REQ-003 The clock is one signal, clk, sampled on its rising edge; reset is asynchronous and active-high, named rst.
REQ-004 Port clk, input, 1 bit, rising-edge sample clock.
REQ-005 Port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 Port D, input, WIDTH bits, data to capture.
REQ-007 Port Q, output, WIDTH bits, stored value.
REQ-008 Port Qn, output, WIDTH bits, bitwise complement of Q; present only when MEMORY_RST_QN_EN is defined.

Function
REQ-009 On each rising edge of clk with rst low, Q takes the value D held at that edge.
- Latency: one edge.
- Q is stable between edges.
REQ-010 D changes between rising edges, including at falling edges, do not affect Q.
REQ-011 Q is a pure register output, with no combinational path from D or clk to Q.
REQ-012 While rst is high, Q equals RST_VAL regardless of clk and D.
- Rising clk edges during reset are ignored.
REQ-013 Reset arriving mid-cycle forces Q to RST_VAL immediately, with no clock edge required.
REQ-014 After rst falls, Q holds RST_VAL until the first rising clk edge with rst low.
- That edge loads D.
REQ-015 If rst falls at the same instant as a clk rising edge, that edge is ignored.
- Q stays RST_VAL until the following edge.
REQ-016 Before the first reset or first clk edge, Q is undefined.
- No initial value is implied.
- Benches shall not check Q in this window.
REQ-017 All bits are independent and identically behaved; bit i of Q depends only on bit i of D.

Reset
REQ-018 rst asserts asynchronously: Q reaches RST_VAL within the same simulation time step as the rst rising transition.
REQ-019 Deassertion takes effect at the next rising clk edge.
REQ-020 There is no synchronous reset or clear.
REQ-021 If MEMORY_RST_QN_EN is defined, Qn equals the complement of RST_VAL during reset.

Configuration
REQ-022 Macro MEMORY_RST_QN_EN is the only compile-time option.
REQ-023 With MEMORY_RST_QN_EN defined:
- Port Qn exists.
- Qn always equals ~Q, derived from the same storage, never a separate flop.
REQ-024 Without MEMORY_RST_QN_EN:
- Port Qn is absent.
- The port list is exactly clk, rst, D, Q.

Structure
REQ-025 Package memory_rst_pkg holds shared items:
- constant MEMORY_RST_MAX_WIDTH = 64;
- default constants for WIDTH (1) and RST_VAL (0);
- typedef memory_rst_word_t, a logic vector of MEMORY_RST_MAX_WIDTH bits.
REQ-026 One sub-module is used: memory_rst_bit, a single-bit async-reset flop with a per-bit reset value.
- It is instantiated WIDTH times by a generate loop.
REQ-027 Elaboration fails with a clear message if WIDTH is outside 1..MEMORY_RST_MAX_WIDTH.

Verification
REQ-028 Capture: WIDTH=1, rst=0, D=1 set before a clk rising edge -> Q=1 after that edge.
REQ-029 Ignored data change: rst=0, Q=1, D toggles 1->0->1 between edges -> Q stays 1 until the next rising edge.
REQ-030 Async reset: Q=1, clk idle high, rst rises -> Q=0 immediately, with no clk edge.
REQ-031 Edge during reset: rst=1, D=1, full clk cycle 1->0->1 -> Q stays 0.
REQ-032 Reset release: rst falls while D=1 -> Q stays 0 until the next rising edge, then Q=1.
REQ-033 Width and options: WIDTH=8, RST_VAL=8'hA5, MEMORY_RST_QN_EN defined; run reset, then D=8'h3C with one edge.
- During reset: Q=8'hA5, Qn=8'h5A.
- After the edge: Q=8'h3C, Qn=8'hC3.
